// File: rtl/core_mem_pkg.sv
// Shared definitions for the core memory responder: FSM encoding, the
// out-of-range read pattern and latency-counter helpers.
package core_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_WR_WAIT = 3'd2,
    ST_RESP    = 3'd3,
    ST_DROP    = 3'd4
  } state_t;

  localparam logic [31:0] OOR_DATA = 32'hDEADBEEF;

  localparam int CNT_W = 4;

  // The counter holds the number of edges still to wait before RESP.
  function automatic logic [CNT_W-1:0] lat_load(input int lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/core_mem_ram.sv
// Single-port 32-bit RAM with synchronous write and registered read,
// written in the plain form that maps onto block RAM.
module core_mem_ram #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/core_mem_responder.sv
// Fixed-latency memory responder for a core's read/write request channels.
// Optional out-of-range checking is enabled with CORE_MEM_OOR_CHECK_EN.
module core_mem_responder
  import core_mem_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] core_ARADDR,
  input  logic        core_ARVALID,
  output logic [31:0] core_RDATA,
  output logic        core_RVALID,
  input  logic [31:0] core_AWADDR,
  input  logic        core_AWVALID,
  input  logic [31:0] core_WDATA,
  output logic        core_BVALID,
  output logic        busy,
  output logic        oor_flag
);

  localparam logic [CNT_W-1:0] RD_LOAD = lat_load(READ_LAT);
  localparam logic [CNT_W-1:0] WR_LOAD = lat_load(WRITE_LAT);

  // Handshake: a valid is a level held by the core until its response
  // pulse; there is no ready, so IDLE accepts whatever valid it samples
  // (write wins a tie) and DROP waits for the served valid to fall.

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              is_wr;
  logic [ADDR_W-1:0] addr_q;
  logic              oor_q;
  logic              flag_q;

  logic [ADDR_W-1:0] aw_word, ar_word, ram_addr;
  logic [31:0]       ram_rdata;
  logic              aw_oor, ar_oor;
  logic              wr_acc, rd_acc, ram_we, served_valid;

  assign aw_word = core_AWADDR[ADDR_W+1:2];
  assign ar_word = core_ARADDR[ADDR_W+1:2];

`ifdef CORE_MEM_OOR_CHECK_EN
  logic unused_addr_bits;
  assign aw_oor = |core_AWADDR[31:ADDR_W+2];
  assign ar_oor = |core_ARADDR[31:ADDR_W+2];
  assign unused_addr_bits = ^{core_AWADDR[1:0], core_ARADDR[1:0]};
`else
  // Without range checking the upper bits simply wrap onto the array.
  logic unused_addr_bits;
  assign aw_oor = 1'b0;
  assign ar_oor = 1'b0;
  assign unused_addr_bits = ^{core_AWADDR[31:ADDR_W+2], core_AWADDR[1:0],
                              core_ARADDR[31:ADDR_W+2], core_ARADDR[1:0]};
`endif

  assign wr_acc       = (state == ST_IDLE) && core_AWVALID;
  assign rd_acc       = (state == ST_IDLE) && core_ARVALID && !core_AWVALID;
  assign ram_we       = wr_acc && !aw_oor;
  assign served_valid = is_wr ? core_AWVALID : core_ARVALID;

  // In IDLE the RAM sees the incoming address so a 1-cycle read has its
  // data registered at the accept edge; afterwards it re-reads addr_q.
  assign ram_addr = (state != ST_IDLE) ? addr_q :
                    (core_AWVALID ? aw_word : ar_word);

  core_mem_ram #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (core_WDATA),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      is_wr  <= 1'b0;
      addr_q <= '0;
      oor_q  <= 1'b0;
      flag_q <= 1'b0;
    end else if (wr_acc) begin
      cnt    <= WR_LOAD;
      is_wr  <= 1'b1;
      addr_q <= aw_word;
      oor_q  <= aw_oor;
      flag_q <= flag_q | aw_oor;
    end else if (rd_acc) begin
      cnt    <= RD_LOAD;
      is_wr  <= 1'b0;
      addr_q <= ar_word;
      oor_q  <= ar_oor;
      flag_q <= flag_q | ar_oor;
    end else if ((state == ST_RD_WAIT || state == ST_WR_WAIT) && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (core_AWVALID) begin
          state_nxt = (WRITE_LAT == 1) ? ST_RESP : ST_WR_WAIT;
        end else if (core_ARVALID) begin
          state_nxt = (READ_LAT == 1) ? ST_RESP : ST_RD_WAIT;
        end
      end
      ST_RD_WAIT, ST_WR_WAIT: begin
        if (cnt == CNT_W'(1)) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: state_nxt = ST_DROP;
      ST_DROP: begin
        if (!served_valid) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    core_RVALID = 1'b0;
    core_BVALID = 1'b0;
    core_RDATA  = '0;
    busy        = (state != ST_IDLE);
    oor_flag    = flag_q;
    if (state == ST_RESP) begin
      if (is_wr) begin
        core_BVALID = 1'b1;
      end else begin
        core_RVALID = 1'b1;
        core_RDATA  = oor_q ? OOR_DATA : ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_core_mem_responder.sv
// Randomized scoreboard bench for core_mem_responder; honours
// CORE_MEM_OOR_CHECK_EN in its reference model.
module tb_core_mem_responder;

  localparam int RL = 2;
  localparam int WL = 1;
  localparam int EW = 65;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          cyc = 0;

  logic [31:0] core_ARADDR = '0, core_AWADDR = '0, core_WDATA = '0;
  logic        core_ARVALID = 1'b0, core_AWVALID = 1'b0;
  logic [31:0] core_RDATA;
  logic        core_RVALID, core_BVALID, busy, oor_flag;

  logic [31:0] b_ARADDR = '0, b_AWADDR = '0, b_WDATA = '0;
  logic        b_ARVALID = 1'b0, b_AWVALID = 1'b0;
  logic [31:0] b_RDATA;
  logic        b_RVALID, b_BVALID, b_busy, b_oor_flag;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  logic [EW-1:0] exp_q[$];
  logic [31:0]   model_mem [int];
  bit            model_flag = 1'b0;

  core_mem_responder #(.ADDR_W(12), .READ_LAT(RL), .WRITE_LAT(WL)) u_dut (
    .clk(clk), .rst(rst),
    .core_ARADDR(core_ARADDR), .core_ARVALID(core_ARVALID),
    .core_RDATA(core_RDATA), .core_RVALID(core_RVALID),
    .core_AWADDR(core_AWADDR), .core_AWVALID(core_AWVALID),
    .core_WDATA(core_WDATA), .core_BVALID(core_BVALID),
    .busy(busy), .oor_flag(oor_flag)
  );

  core_mem_responder #(.ADDR_W(12), .READ_LAT(1), .WRITE_LAT(3)) u_dut2 (
    .clk(clk), .rst(rst),
    .core_ARADDR(b_ARADDR), .core_ARVALID(b_ARVALID),
    .core_RDATA(b_RDATA), .core_RVALID(b_RVALID),
    .core_AWADDR(b_AWADDR), .core_AWVALID(b_AWVALID),
    .core_WDATA(b_WDATA), .core_BVALID(b_BVALID),
    .busy(b_busy), .oor_flag(b_oor_flag)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int word_of(input logic [31:0] a);
    return int'(a[13:2]);
  endfunction

  function automatic bit oor_of(input logic [31:0] a);
`ifdef CORE_MEM_OOR_CHECK_EN
    return |a[31:14];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (oor_of(a)) return 32'hDEADBEEF;
    if (model_mem.exists(word_of(a))) return model_mem[word_of(a)];
    return 32'h0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d);
    if (oor_of(a)) model_flag = 1'b1;
    else model_mem[word_of(a)] = d;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      logic [EW-1:0] e;
      if (!core_RVALID) check("rdata_zero", core_RDATA, 32'h0);
      if (core_RVALID || core_BVALID) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resp: rvalid=%b bvalid=%b with empty queue (cycle %0d)",
                   core_RVALID, core_BVALID, cyc);
        end else begin
          e = exp_q.pop_front();
          check("resp_kind", {31'h0, core_BVALID}, {31'h0, e[64]});
          check("resp_single", {31'h0, core_RVALID & core_BVALID}, 32'h0);
          if (!e[64]) check("rdata", core_RDATA, e[63:32]);
          if (int'(e[31:0]) != -1) check("resp_cycle", cyc, e[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_resp(input bit wr);
    bit got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (wr ? core_BVALID : core_RVALID) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL resp_timeout: no %s response within 30 cycles", wr ? "write" : "read");
    end
  endtask

  task automatic hold_busy(input int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("busy_hold", {31'h0, busy}, 32'h1);
    end
  endtask

  task automatic finish_txn();
    @(negedge clk);
    check("oor_flag", {31'h0, oor_flag}, {31'h0, model_flag});
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int hold);
    @(negedge clk);
    check("idle_before", {31'h0, busy}, 32'h0);
    core_AWADDR = a; core_WDATA = d; core_AWVALID = 1'b1;
    exp_q.push_back({1'b1, d, 32'(cyc + WL)});
    model_write(a, d);
    wait_resp(1'b1);
    hold_busy(hold);
    core_AWVALID = 1'b0; core_AWADDR = $urandom; core_WDATA = $urandom;
    finish_txn();
  endtask

  task automatic do_read(input logic [31:0] a, input int hold);
    @(negedge clk);
    check("idle_before", {31'h0, busy}, 32'h0);
    core_ARADDR = a; core_ARVALID = 1'b1;
    exp_q.push_back({1'b0, model_read(a), 32'(cyc + RL)});
    if (oor_of(a)) model_flag = 1'b1;
    wait_resp(1'b0);
    hold_busy(hold);
    core_ARVALID = 1'b0; core_ARADDR = $urandom;
    finish_txn();
  endtask

  // Simultaneous request: write first, then the held read (timing not pinned).
  task automatic do_both(input logic [31:0] wa, input logic [31:0] wd, input logic [31:0] ra);
    @(negedge clk);
    check("idle_before", {31'h0, busy}, 32'h0);
    core_AWADDR = wa; core_WDATA = wd; core_AWVALID = 1'b1;
    core_ARADDR = ra; core_ARVALID = 1'b1;
    exp_q.push_back({1'b1, wd, 32'(cyc + WL)});
    model_write(wa, wd);
    exp_q.push_back({1'b0, model_read(ra), 32'hFFFF_FFFF});
    if (oor_of(ra)) model_flag = 1'b1;
    wait_resp(1'b1);
    core_AWVALID = 1'b0;
    wait_resp(1'b0);
    core_ARVALID = 1'b0;
    finish_txn();
  endtask

  task automatic reset_pulse();
    #1 rst = 1'b0;
    model_flag = 1'b0;
    #1;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_rvalid", {31'h0, core_RVALID}, 32'h0);
    check("rst_bvalid", {31'h0, core_BVALID}, 32'h0);
    check("rst_oor", {31'h0, oor_flag}, 32'h0);
    @(negedge clk);
    core_ARVALID = 1'b0; core_AWVALID = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_read_reset(input logic [31:0] a);
    @(negedge clk);
    core_ARADDR = a; core_ARVALID = 1'b1;
    @(posedge clk);
    reset_pulse();
  endtask

  task automatic do_write_reset(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    core_AWADDR = a; core_WDATA = d; core_AWVALID = 1'b1;
    model_write(a, d);
    @(posedge clk);
    reset_pulse();
  endtask

  task automatic dut2_txn(input logic [31:0] a, input logic [31:0] d);
    int c0;
    int seen;
    logic [31:0] got;
    @(negedge clk);
    b_AWADDR = a; b_WDATA = d; b_AWVALID = 1'b1; c0 = cyc; seen = -100;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b_BVALID) begin seen = cyc; break; end
    end
    check("dut2_wr_lat", 32'(seen - c0), 32'd3);
    b_AWVALID = 1'b0;
    @(negedge clk);
    check("dut2_bpulse", {31'h0, b_BVALID}, 32'h0);
    @(negedge clk);
    b_ARADDR = a; b_ARVALID = 1'b1; c0 = cyc; seen = -100; got = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b_RVALID) begin seen = cyc; got = b_RDATA; break; end
    end
    check("dut2_rd_lat", 32'(seen - c0), 32'd1);
    check("dut2_rdata", got, d);
    b_ARVALID = 1'b0;
    @(negedge clk);
    check("dut2_rpulse", {31'h0, b_RVALID}, 32'h0);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
    if ($urandom_range(0, 3) == 0) a = a | (32'($urandom_range(1, 255)) << 14);
    return a;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("reset_rvalid", {31'h0, core_RVALID}, 32'h0);
    check("reset_bvalid", {31'h0, core_BVALID}, 32'h0);
    check("reset_rdata", core_RDATA, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_oor", {31'h0, oor_flag}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    for (int i = 0; i < 16; i++) do_write(32'(i * 4), $urandom, 0);

    do_write(32'h10, 32'hCAFEF00D, 0);
    do_read(32'h10, 0);
    do_both(32'h20, 32'h11111111, 32'h20);
    do_read(32'h10, 5);

    do_write(32'h4, 32'h01010101, 0);
    do_write(32'h0000_4004, 32'hBADC0DE5, 0);
    do_read(32'h0000_4004, 0);
    do_read(32'h4, 0);

    do_read_reset(32'h10);
    do_read(32'h10, 0);
    do_write_reset(32'h14, 32'h5A5A1234);
    do_read(32'h14, 0);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 2))
        0: do_write(rand_addr(), $urandom, $urandom_range(0, 3));
        1: do_read(rand_addr(), $urandom_range(0, 3));
        default: do_both(rand_addr(), $urandom, rand_addr());
      endcase
    end

    dut2_txn(32'h8, 32'h3C3C_A5A5);
    dut2_txn(32'h40, $urandom);
    dut2_txn(32'h0FFC, $urandom);

    repeat (4) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
